// File: rtl/ucsbece154a_rf_pkg.sv
// ucsbece154a_rf_pkg: register file geometry and ABI register indices
package ucsbece154a_rf_pkg;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_SP = 5'd2;
    localparam logic [4:0] REG_GP = 5'd3;
    localparam logic [4:0] REG_TP = 5'd4;
    localparam logic [4:0] REG_T0 = 5'd5;
    localparam logic [4:0] REG_S0 = 5'd8;
    localparam logic [4:0] REG_A0 = 5'd10;
    localparam logic [4:0] REG_A1 = 5'd11;
endpackage

// File: rtl/ucsbece154a_rr_arb.sv
// ucsbece154a_rr_arb: combinational round-robin pick starting at ptr, one-hot grant plus index
module ucsbece154a_rr_arb #(
    parameter int N = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [PW-1:0] j;
    // Walk offsets from farthest to nearest so the closest valid requester after ptr wins.
    always_comb begin
        grant = '0;
        idx = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N);
            if (valid[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = j;
            end
        end
    end
    assign any = |valid;
endmodule

// File: rtl/ucsbece154a_rf_wrarb.sv
// ucsbece154a_rf_wrarb: round-robin arbiter for the RF write port with a pending-write scoreboard
module ucsbece154a_rf_wrarb
    import ucsbece154a_rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               rf_we3_o,
    output logic [AW-1:0]      rf_a3_o,
    output logic [DW-1:0]      rf_wd3_o,
    input  logic               iss_valid_i,
    input  logic [AW-1:0]      iss_rd_i,
    output logic               iss_ready_o,
    input  logic [AW-1:0]      chk_a1_i,
    input  logic [AW-1:0]      chk_a2_i,
    output logic               hazard_o,
    output logic [NREGS-1:0]   busy_o
);
    localparam int PW = $clog2(NREQ);
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);
    logic [PW-1:0] ptr, idx, ptr_nxt;
    logic any;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [NREGS-1:0] busy_nxt;
    ucsbece154a_rr_arb #(.N(NREQ), .PW(PW)) u_arb (
        .valid(req_valid_i),
        .ptr(ptr),
        .grant(req_ready_o),
        .idx(idx),
        .any(any)
    );
    assign sel_addr = req_addr_i[idx*AW +: AW];
    assign sel_data = req_data_i[idx*DW +: DW];
    assign ptr_nxt = idx == PW'(NREQ - 1) ? '0 : idx + 1'b1;
    // A write retiring this cycle frees its register in time for a same-cycle reissue.
    assign iss_ready_o = !busy_o[iss_rd_i] || (rf_we3_o && rf_a3_o == iss_rd_i) || iss_rd_i == ZERO;
    assign hazard_o = busy_o[chk_a1_i] | busy_o[chk_a2_i];
    always_comb begin
        busy_nxt = busy_o;
        if (rf_we3_o) busy_nxt[rf_a3_o] = 1'b0;
        if (iss_valid_i && iss_ready_o && iss_rd_i != ZERO) busy_nxt[iss_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            rf_we3_o <= 1'b0;
            rf_a3_o <= '0;
            rf_wd3_o <= '0;
            busy_o <= '0;
        end else begin
            ptr <= any ? ptr_nxt : ptr;
            rf_we3_o <= any && sel_addr != ZERO;
            rf_a3_o <= any ? sel_addr : rf_a3_o;
            rf_wd3_o <= any ? sel_data : rf_wd3_o;
            busy_o <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_ucsbece154a_rf_wrarb.sv
// tb_ucsbece154a_rf_wrarb: scoreboard bench for the RF write arbiter
module tb_ucsbece154a_rf_wrarb;
    localparam int NREQ = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0] req_ready;
    logic rf_we3;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd3;
    logic iss_valid = 1'b0;
    logic [AW-1:0] iss_rd = '0;
    logic iss_ready;
    logic [AW-1:0] chk_a1 = '0;
    logic [AW-1:0] chk_a2 = '0;
    logic hazard;
    logic [31:0] busy;
    wr_t sbq[$];
    int n_cmp = 0;
    int n_err = 0;
    int mptr = 0;

    ucsbece154a_rf_wrarb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready),
        .rf_we3_o(rf_we3), .rf_a3_o(rf_a3), .rf_wd3_o(rf_wd3),
        .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_ready_o(iss_ready),
        .chk_a1_i(chk_a1), .chk_a2_i(chk_a2), .hazard_o(hazard), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic v);
        req_addr[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
        req_valid[k] = v;
    endtask

    // Reference round-robin pick from the bench's own pointer; -1 when nothing is valid.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Accepts the model's pick: advances the model pointer and queues any real RF write.
    function automatic void model_accept(input int g);
        if (g < 0) return;
        if (req_addr[g*AW +: AW] != '0) sbq.push_back('{a: req_addr[g*AW +: AW], d: req_data[g*DW +: DW]});
        mptr = (g + 1) % NREQ;
    endfunction

    function automatic wr_t pop_exp();
        wr_t e;
        e = '{a: 'x, d: 'x};
        if (sbq.size() != 0) e = sbq.pop_front();
        return e;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        mptr = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            n_cmp += 3;
            if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL reset_we3 c%0d got %b want 0", c, rf_we3); end
            if (busy !== 32'h0) begin n_err++; $display("FAIL reset_busy c%0d got %h want 0", c, busy); end
            if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready c%0d got %b want 000", c, req_ready); end
        end
    endtask

    task automatic test_single;
        int g;
        wr_t e;
        iss_valid = 1'b1;
        iss_rd = 5'd5;
        #1;
        n_cmp++;
        if (iss_ready !== 1'b1) begin n_err++; $display("FAIL single_iss_ready got %b want 1", iss_ready); end
        tick;
        iss_valid = 1'b0;
        n_cmp++;
        if (busy !== 32'h20) begin n_err++; $display("FAIL single_busy_set got %h want 00000020", busy); end
        set_req(0, 5'd5, 32'hDEADBEEF, 1'b1);
        #1;
        g = model_pick(req_valid, mptr);
        n_cmp++;
        if (req_ready !== onehot(g)) begin n_err++; $display("FAIL single_ready got %b want %b", req_ready, onehot(g)); end
        model_accept(g);
        tick;
        set_req(0, '0, '0, 1'b0);
        e = pop_exp();
        n_cmp += 4;
        if (rf_we3 !== 1'b1) begin n_err++; $display("FAIL single_we3 got %b want 1", rf_we3); end
        if (rf_a3 !== e.a) begin n_err++; $display("FAIL single_a3 got %0d want %0d", rf_a3, e.a); end
        if (rf_wd3 !== e.d) begin n_err++; $display("FAIL single_wd3 got %h want %h", rf_wd3, e.d); end
        if (busy[5] !== 1'b1) begin n_err++; $display("FAIL single_busy_hold got %b want 1", busy[5]); end
        tick;
        n_cmp += 2;
        if (busy !== 32'h0) begin n_err++; $display("FAIL single_busy_clear got %h want 0", busy); end
        if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL single_we3_idle got %b want 0", rf_we3); end
    endtask

    task automatic test_fairness;
        int g;
        wr_t e;
        for (int k = 0; k < NREQ; k++) set_req(k, AW'(10 + k), 32'hF000_0000 | k, 1'b1);
        for (int c = 0; c < 6; c++) begin
            set_req(c % NREQ, AW'(10 + c), 32'hA5A5_0000 | c, 1'b1);
            #1;
            g = model_pick(req_valid, mptr);
            n_cmp++;
            if (req_ready !== onehot(g)) begin n_err++; $display("FAIL fair_ready c%0d got %b want %b", c, req_ready, onehot(g)); end
            model_accept(g);
            tick;
            e = pop_exp();
            n_cmp += 3;
            if (rf_we3 !== 1'b1) begin n_err++; $display("FAIL fair_we3 c%0d got %b want 1", c, rf_we3); end
            if (rf_a3 !== e.a) begin n_err++; $display("FAIL fair_a3 c%0d got %0d want %0d", c, rf_a3, e.a); end
            if (rf_wd3 !== e.d) begin n_err++; $display("FAIL fair_wd3 c%0d got %h want %h", c, rf_wd3, e.d); end
        end
        req_valid = '0;
        tick;
        n_cmp++;
        if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL fair_idle got %b want 0", rf_we3); end
    endtask

    task automatic test_x0;
        int g;
        wr_t e;
        set_req(1, 5'd0, 32'h1234, 1'b1);
        #1;
        g = model_pick(req_valid, mptr);
        n_cmp++;
        if (req_ready !== 3'b010) begin n_err++; $display("FAIL x0_ready got %b want 010", req_ready); end
        model_accept(g);
        tick;
        n_cmp += 2;
        if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL x0_we3 got %b want 0", rf_we3); end
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL x0_busy0 got %b want 0", busy[0]); end
        // All three valid: only a pointer sitting at 2 grants requester 2.
        set_req(0, 5'd3, 32'h30, 1'b1);
        set_req(1, 5'd4, 32'h40, 1'b1);
        set_req(2, 5'd6, 32'h60, 1'b1);
        #1;
        g = model_pick(req_valid, mptr);
        n_cmp++;
        if (req_ready !== 3'b100 || req_ready !== onehot(g)) begin n_err++; $display("FAIL x0_rr_adv got %b want 100", req_ready); end
        model_accept(g);
        tick;
        req_valid = '0;
        e = pop_exp();
        n_cmp += 2;
        if (rf_we3 !== 1'b1) begin n_err++; $display("FAIL x0_next_we3 got %b want 1", rf_we3); end
        if (rf_a3 !== e.a) begin n_err++; $display("FAIL x0_next_a3 got %0d want %0d", rf_a3, e.a); end
        tick;
    endtask

    task automatic test_hazard;
        int g;
        wr_t e;
        iss_valid = 1'b1;
        iss_rd = 5'd7;
        tick;
        iss_valid = 1'b0;
        chk_a1 = 5'd7;
        chk_a2 = 5'd0;
        #1;
        n_cmp += 2;
        if (busy !== 32'h80) begin n_err++; $display("FAIL haz_busy got %h want 00000080", busy); end
        if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_a1 got %b want 1", hazard); end
        chk_a1 = 5'd0;
        #1;
        n_cmp++;
        if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_x0 got %b want 0", hazard); end
        chk_a2 = 5'd7;
        iss_valid = 1'b1;
        #1;
        n_cmp += 2;
        if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_a2 got %b want 1", hazard); end
        if (iss_ready !== 1'b0) begin n_err++; $display("FAIL haz_waw got %b want 0", iss_ready); end
        set_req(2, 5'd7, 32'h77, 1'b1);
        #1;
        g = model_pick(req_valid, mptr);
        n_cmp++;
        if (req_ready !== onehot(g)) begin n_err++; $display("FAIL haz_ready got %b want %b", req_ready, onehot(g)); end
        model_accept(g);
        tick;
        req_valid = '0;
        e = pop_exp();
        #1;
        n_cmp += 3;
        if (rf_we3 !== 1'b1 || rf_a3 !== e.a) begin n_err++; $display("FAIL haz_wb got we3=%b a3=%0d want we3=1 a3=%0d", rf_we3, rf_a3, e.a); end
        if (rf_wd3 !== e.d) begin n_err++; $display("FAIL haz_wd3 got %h want %h", rf_wd3, e.d); end
        if (iss_ready !== 1'b1) begin n_err++; $display("FAIL haz_bypass_ready got %b want 1", iss_ready); end
        tick;
        iss_valid = 1'b0;
        n_cmp += 2;
        if (busy !== 32'h80) begin n_err++; $display("FAIL haz_set_wins got %h want 00000080", busy); end
        if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL haz_idle got %b want 0", rf_we3); end
        set_req(0, 5'd7, 32'h700, 1'b1);
        #1;
        g = model_pick(req_valid, mptr);
        model_accept(g);
        tick;
        req_valid = '0;
        e = pop_exp();
        n_cmp++;
        if (rf_a3 !== e.a || rf_wd3 !== e.d) begin n_err++; $display("FAIL haz_second_wb got %0d/%h want %0d/%h", rf_a3, rf_wd3, e.a, e.d); end
        tick;
        n_cmp += 2;
        if (busy !== 32'h0) begin n_err++; $display("FAIL haz_clear got %h want 0", busy); end
        if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_clean got %b want 0", hazard); end
        chk_a2 = '0;
    endtask

    task automatic test_reset_mid;
        int g;
        wr_t e;
        iss_valid = 1'b1;
        iss_rd = 5'd9;
        tick;
        iss_valid = 1'b0;
        set_req(2, 5'd9, 32'hAA, 1'b1);
        #1;
        n_cmp++;
        if (req_ready !== 3'b100) begin n_err++; $display("FAIL rmid_ready got %b want 100", req_ready); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req_valid = '0;
        mptr = 0;
        n_cmp += 2;
        if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL rmid_we3 got %b want 0", rf_we3); end
        if (busy !== 32'h0) begin n_err++; $display("FAIL rmid_busy got %h want 0", busy); end
        for (int k = 0; k < NREQ; k++) set_req(k, AW'(20 + k), 32'hB0 + k, 1'b1);
        #1;
        g = model_pick(req_valid, mptr);
        n_cmp++;
        if (req_ready !== 3'b001 || req_ready !== onehot(g)) begin n_err++; $display("FAIL rmid_ptr0 got %b want 001", req_ready); end
        model_accept(g);
        tick;
        req_valid = '0;
        e = pop_exp();
        n_cmp++;
        if (rf_we3 !== 1'b1 || rf_a3 !== e.a || rf_wd3 !== e.d) begin n_err++; $display("FAIL rmid_wb got %b/%0d/%h want 1/%0d/%h", rf_we3, rf_a3, rf_wd3, e.a, e.d); end
        tick;
        n_cmp += 2;
        if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL rmid_idle got %b want 0", rf_we3); end
        if (sbq.size() != 0) begin n_err++; $display("FAIL sb_drain got %0d left want 0", sbq.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_x0;
        test_hazard;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
